// File: rtl/pht_pkg.sv
// Shared definitions for the pattern history table: counter encodings, update FSM
// states and the 2-bit saturating counter step.
package pht_pkg;

    localparam logic [1:0] PHT_SNT = 2'b00;
    localparam logic [1:0] PHT_WNT = 2'b01;
    localparam logic [1:0] PHT_WT  = 2'b10;
    localparam logic [1:0] PHT_ST  = 2'b11;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } pht_state_e;

    // Saturating step: taken moves toward strongly-taken, not-taken toward strongly-NT.
    function automatic logic [1:0] pht_sat_upd(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        case (ctr)
            PHT_SNT: nxt = taken ? PHT_WNT : PHT_SNT;
            PHT_WNT: nxt = taken ? PHT_WT  : PHT_SNT;
            PHT_WT:  nxt = taken ? PHT_ST  : PHT_WNT;
            default: nxt = taken ? PHT_ST  : PHT_WT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/pht_upd_fifo.sv
// Small synchronous FIFO with full/empty flags; head is read straight from storage.
// Shared by the PHT and BTB update paths.
module pht_upd_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit tells full from empty when the indices match.
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/pht_upd_ctrl.sv
// PHT update controller: init sweep after reset, then a two-stage read-modify-write
// of saturating counters over RAM ports B (read) and C (write) with write forwarding.
module pht_upd_ctrl
    import pht_pkg::*;
#(
    parameter int         IDX_W      = 10,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [1:0] INIT_VAL   = PHT_WNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [IDX_W-1:0] upd_index,
    input  logic             upd_taken,
    output logic             ram_rd_en,
    output logic [IDX_W-1:0] ram_rd_addr,
    input  logic [1:0]       ram_rd_data,
    output logic             ram_wr_en,
    output logic [IDX_W-1:0] ram_wr_addr,
    output logic [1:0]       ram_wr_data,
    output logic             init_busy
);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             taken;
    } upd_ent_t;

    localparam int STAGES = 2;

    pht_state_e       state;
    pht_state_e       state_nx;
    logic [IDX_W-1:0] sweep;
    upd_ent_t         push_ent;
    upd_ent_t         head_ent;
    upd_ent_t         wr_ent;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    // vld_pipe[1]: WR stage holds an update; vld_pipe[2]: last cycle's write is forwardable
    logic [STAGES:1]  vld_pipe;
    logic [IDX_W-1:0] fwd_addr;
    logic [1:0]       fwd_data;
    logic [1:0]       old_ctr;
    logic [1:0]       new_ctr;

    assign push_ent  = '{idx: upd_index, taken: upd_taken};
    assign upd_ready = ~rst & ~fifo_full;
    assign push      = upd_valid & upd_ready;

    pht_upd_fifo #(
        .W     (IDX_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_ent),
        .pop       (pop),
        .head      (head_ent),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Port B returns the pre-write value on a same-cycle collision, so the
    // previous write must override it.
    assign old_ctr = (vld_pipe[2] && (fwd_addr == wr_ent.idx)) ? fwd_data : ram_rd_data;
    assign new_ctr = pht_sat_upd(old_ctr, wr_ent.taken);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_INIT;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        pop         = 1'b0;
        init_busy   = 1'b1;
        ram_rd_en   = 1'b0;
        ram_rd_addr = '0;
        ram_wr_en   = 1'b0;
        ram_wr_addr = '0;
        ram_wr_data = '0;
        if (!rst) begin
            case (state)
                ST_INIT: begin
                    ram_wr_en   = 1'b1;
                    ram_wr_addr = sweep;
                    ram_wr_data = INIT_VAL;
                    if (&sweep) state_nx = ST_RUN;
                end
                ST_RUN: begin
                    init_busy = 1'b0;
                    pop       = ~fifo_empty;
                    ram_rd_en = pop;
                    if (pop) ram_rd_addr = head_ent.idx;
                    ram_wr_en = vld_pipe[1];
                    if (vld_pipe[1]) begin
                        ram_wr_addr = wr_ent.idx;
                        ram_wr_data = new_ctr;
                    end
                end
                default: state_nx = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sweep    <= '0;
            vld_pipe <= '0;
            wr_ent   <= '0;
            fwd_addr <= '0;
            fwd_data <= '0;
        end else begin
            if (state == ST_INIT) sweep <= sweep + IDX_W'(1);
            // Forward-valid only ever follows a RUN write, so it is clear entering RUN.
            vld_pipe <= {vld_pipe[1] & (state == ST_RUN), pop};
            if (pop) wr_ent <= head_ent;
            if (vld_pipe[1]) begin
                fwd_addr <= wr_ent.idx;
                fwd_data <= new_ctr;
            end
        end
    end

endmodule
